full_adder_cell: RTL and testbench
==================================

// Module: full_adder_cell
// PURPOSE
//   1-bit full adder: the bit slice of the 9-bit ripple-carry parallel_adder in the 8-bit ALU.
//   The combinational sum/cout path is what the ripple chain uses.
//   It must have zero latency so carries ripple within one cycle.
//   An optional registered copy supports pipelined or debug use.
//   Generate/propagate outputs support carry-lookahead use.
//   A built-in dual-implementation self-check flags faults.
// PARAMETERS
//   REG_OUT   1  1 = registered outputs sum_q/cout_q active; 0 = they are held at 0
//   SELFCHK   1  1 = redundant truth-table check drives err; 0 = err tied 0
// PORTS
//   clk    in   1  single clock, rising edge
//   rst    in   1  synchronous, active-high reset
//   a      in   1  operand bit x[i]
//   b      in   1  operand bit y[i]
//   cin    in   1  carry in (LSB cell: adder cin; others: cout of cell i-1)
//   en     in   1  capture enable for registered outputs
//   sum    out  1  combinational sum = a ^ b ^ cin
//   cout   out  1  combinational carry = (a&b) | (cin&(a^b))
//   g      out  1  carry generate = a & b
//   p      out  1  carry propagate = a ^ b
//   sum_q  out  1  registered sum
//   cout_q out  1  registered cout
//   err    out  1  sticky self-check mismatch flag
// BEHAVIOUR
//   - Combinational outputs:
//     - sum, cout, g and p depend only on a, b and cin, with zero cycle latency.
//     - They do not depend on clk, rst or en, so the ripple chain settles purely combinationally.
//   - Arithmetic rule: {cout,sum} = a + b + cin (2-bit result, range 0..3).
//   - Registered path (REG_OUT=1):
//     - On a clk rising edge with rst=1: sum_q=0, cout_q=0, err=0.
//     - Otherwise, if en=1: sum_q<=sum, cout_q<=cout (1-cycle latency).
//     - If en=0: hold the current values.
//   - rst has priority over en.
//   - A reset asserted mid-operation clears the registers on that edge.
//   - Reset leaves sum/cout/g/p unaffected.
//   - Self-check (SELFCHK=1):
//     - A second implementation computes sum/cout by an 8-entry truth-table lookup on {a,b,cin}.
//     - On each clk edge with rst=0, if the lookup result differs from the XOR/majority result, err<=1.
//     - err stays set until rst.
//     - err must never assert in a fault-free design.
//   - Inputs are never X-propagated intentionally; all 8 input combinations are legal.
//   - No handshake and no state machine.
// TESTING
//   - Exhaustive combinational check: all 8 {a,b,cin} -> {cout,sum} = 00,01,01,10,01,10,10,11.
//     - Also check g = a&b and p = a^b in every case.
//   - Registered path: rst=1 for one edge -> sum_q=cout_q=err=0.
//     - Then a=1, b=1, cin=1, en=1 -> after 1 edge sum_q=1, cout_q=1.
//   - Hold: en=0, change inputs to 0/0/0 -> sum_q/cout_q stay 1.
//     - Combinational sum=0, cout=0 immediately.
//   - Reset mid-operation: with sum_q=1, assert rst with en=1 -> next edge sum_q=cout_q=0.
//   - Chain use: 9 cells rippled as parallel_adder.
//     - Sweep x,y over 0..255 each with cin=0 and 1 -> {cout,sum[8:0]} == x+y+cin for all cases.
//     - Example: 255+255+1 -> 511; err stays 0 throughout.

Source files
------------

// File: rtl/full_adder_cell.sv
// 1-bit full adder slice for the ripple-carry parallel_adder.
// Provides a combinational sum/carry, a generate/propagate pair, optional registered copies and a redundant self-check.
module full_adder_cell #(
  parameter int REG_OUT = 1,
  parameter int SELFCHK = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic en,
  output logic sum,
  output logic cout,
  output logic g,
  output logic p,
  output logic sum_q,
  output logic cout_q,
  output logic err
);

  // Zero-latency path used by the ripple chain; independent of clk/rst/en.
  assign g    = a & b;
  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = g | (cin & p);

  generate
    if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q  <= 1'b0;
          cout_q <= 1'b0;
        end else if (en) begin
          sum_q  <= sum;
          cout_q <= cout;
        end
      end
    end else begin : g_noreg
      assign sum_q  = 1'b0;
      assign cout_q = 1'b0;
    end
  endgenerate

  generate
    if (SELFCHK != 0) begin : g_chk
      logic [1:0] tt;

      // Independent truth-table implementation, {cout,sum} indexed by {a,b,cin}.
      always_comb begin
        tt = '0;
        case ({a, b, cin})
          3'b000:  tt = 2'b00;
          3'b001:  tt = 2'b01;
          3'b010:  tt = 2'b01;
          3'b011:  tt = 2'b10;
          3'b100:  tt = 2'b01;
          3'b101:  tt = 2'b10;
          3'b110:  tt = 2'b10;
          3'b111:  tt = 2'b11;
          default: tt = '0;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          err <= 1'b0;
        end else if (tt != {cout, sum}) begin
          err <= 1'b1;
        end
      end
    end else begin : g_nochk
      assign err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_cell.sv
// Directed bench for full_adder_cell: truth table, registered path, and a 9-cell ripple sweep.
module tb_full_adder_cell;

  logic clk = 1'b0;
  logic rst, a, b, cin, en;
  logic sum, cout, g, p, sum_q, cout_q, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  full_adder_cell #(.REG_OUT(1), .SELFCHK(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
    .sum(sum), .cout(cout), .g(g), .p(p),
    .sum_q(sum_q), .cout_q(cout_q), .err(err)
  );

  // Ripple chain of 9 cells forming the parallel_adder
  logic [8:0] xs, ys, cs, cg, cp, csq, ccq, cerr;
  logic [9:0] cc;
  logic       ccin;

  assign cc[0] = ccin;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_chain
      full_adder_cell #(.REG_OUT(1), .SELFCHK(1)) u_cell (
        .clk(clk), .rst(rst), .a(xs[gi]), .b(ys[gi]), .cin(cc[gi]), .en(1'b1),
        .sum(cs[gi]), .cout(cc[gi+1]), .g(cg[gi]), .p(cp[gi]),
        .sum_q(csq[gi]), .cout_q(ccq[gi]), .err(cerr[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed tables indexed by {a,b,cin}
  logic [1:0] exp_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic       exp_g  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       exp_p  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    xs = '0; ys = '0; ccin = 1'b0;
    tick();
    check("rst_sum_q", 32'(sum_q), 32'd0);
    check("rst_cout_q", 32'(cout_q), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a, b, cin} = v;
      #1;
      check($sformatf("comb_cs_%0d", i), 32'({cout, sum}), 32'(exp_cs[i]));
      check($sformatf("comb_g_%0d", i), 32'(g), 32'(exp_g[i]));
      check($sformatf("comb_p_%0d", i), 32'(p), 32'(exp_p[i]));
    end

    a = 1'b1; b = 1'b1; cin = 1'b1; en = 1'b1;
    tick();
    check("cap_sum_q", 32'(sum_q), 32'd1);
    check("cap_cout_q", 32'(cout_q), 32'd1);

    en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    #1;
    check("hold_sum", 32'(sum), 32'd0);
    check("hold_cout", 32'(cout), 32'd0);
    tick();
    check("hold_sum_q", 32'(sum_q), 32'd1);
    check("hold_cout_q", 32'(cout_q), 32'd1);

    a = 1'b1; b = 1'b1; cin = 1'b1; en = 1'b1; rst = 1'b1;
    tick();
    check("midrst_sum_q", 32'(sum_q), 32'd0);
    check("midrst_cout_q", 32'(cout_q), 32'd0);
    check("midrst_sum", 32'(sum), 32'd1);
    check("midrst_cout", 32'(cout), 32'd1);
    rst = 1'b0;

    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        for (int c = 0; c < 2; c++) begin
          xs = {1'b0, 8'(x)};
          ys = {1'b0, 8'(y)};
          ccin = 1'(c);
          #1;
          check("chain_sum", 32'({cc[9], cs}), 32'(x + y + c));
        end
      end
    end

    xs = 9'd255; ys = 9'd255; ccin = 1'b1;
    #1;
    check("chain_max", 32'({cc[9], cs}), 32'd511);
    check("chain_g", 32'(cg), 32'h0FF);
    check("chain_p", 32'(cp), 32'h000);
    tick();
    check("chain_reg", 32'({ccq[8], csq}), 32'd511);
    check("chain_err", 32'(cerr), 32'd0);
    check("dut_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
